blink_multi: RTL

BLINK_MULTI -- requirements
Module: blink_multi

---
 rtl/blink_multi.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/blink_multi.sv
// Multi-channel LED blinker: shared tick prescaler plus per-channel OFF/ON/BLINK/BURST sequencers.
// Config writes are single-cycle strobes; ack/err and channel outputs appear one cycle after the write.
module blink_multi #(
  parameter int FREQUENCY = 25_000_000,
  parameter int TICK_HZ   = 10,
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_i,
  input  logic [$clog2(CHANNELS):0]   ch_i,
  input  logic [1:0]                  mode_i,
  input  logic [CNT_W-1:0]            half_i,
  input  logic [CNT_W-1:0]            burst_i,
  output logic                        ack_o,
  output logic                        err_o,
  output logic                        tick_o,
  output logic [CHANNELS-1:0]         blink_o
);

  localparam int T    = FREQUENCY / TICK_HZ;
  localparam int DIV  = T - 1;
  localparam int PW   = (T > 1) ? $clog2(T) : 1;
  localparam int CH_W = $clog2(CHANNELS) + 1;
  localparam int PH_W = CNT_W + 2;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;

  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON_PH  = 2'd1,
    OFF_PH = 2'd2,
    PAUSE  = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Shared timebase
  // ------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          presc_wrap;

  assign presc_wrap = (presc == PW'(DIV));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc  <= '0;
      tick_o <= 1'b0;
    end else begin
      presc  <= presc_wrap ? '0 : presc + PW'(1);
      tick_o <= presc_wrap;
    end
  end

  // ------------------------------------------------------------------
  // Write decode and handshake pulses
  // ------------------------------------------------------------------
  logic             ch_ok;
  logic             wr_ok;
  logic             wr_bad;
  logic [CNT_W-1:0] half_eff;

  assign ch_ok    = (ch_i < CH_W'(CHANNELS));
  assign wr_ok    = wr_i && ch_ok;
  assign wr_bad   = wr_i && !ch_ok;
  assign half_eff = (half_i == '0) ? CNT_ONE : half_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      ack_o <= wr_ok;
      err_o <= wr_bad;
    end
  end

  // ------------------------------------------------------------------
  // Per-channel sequencers
  // ------------------------------------------------------------------
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             out_q, out_d;
    logic             sel;
    logic [PH_W-1:0]  len_m1;
    logic             phase_end;
    logic             burst_done;

    assign sel = wr_ok && (ch_i == CH_W'(g));

    // PAUSE lasts four half-periods; the other running phases last one.
    assign len_m1    = (state_q == PAUSE) ? ({half_q, 2'b00} - PH_ONE)
                                          : ({2'b00, half_q} - PH_ONE);
    assign phase_end = (phase_q == len_m1);

    // B==0 never completes a burst, so BURST degenerates to BLINK.
    assign burst_done = (mode_q == M_BURST) && (burst_q != '0)
                        && ((pulse_q + CNT_ONE) == burst_q);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= IDLE;
        mode_q  <= M_OFF;
        half_q  <= CNT_ONE;
        burst_q <= '0;
        pulse_q <= '0;
        phase_q <= '0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        mode_q  <= mode_d;
        half_q  <= half_d;
        burst_q <= burst_d;
        pulse_q <= pulse_d;
        phase_q <= phase_d;
        out_q   <= out_d;
      end
    end

    always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      half_d  = half_q;
      burst_d = burst_q;
      pulse_d = pulse_q;
      phase_d = phase_q;
      if (sel) begin
        // A write always restarts the channel and swallows a coincident tick.
        mode_d  = mode_i;
        half_d  = half_eff;
        burst_d = burst_i;
        pulse_d = '0;
        phase_d = '0;
        state_d = (mode_i == M_BLINK || mode_i == M_BURST) ? ON_PH : IDLE;
      end else if (tick_o && state_q != IDLE) begin
        if (!phase_end) begin
          phase_d = phase_q + PH_ONE;
        end else begin
          phase_d = '0;
          case (state_q)
            ON_PH: begin
              pulse_d = pulse_q + CNT_ONE;
              state_d = burst_done ? PAUSE : OFF_PH;
            end
            OFF_PH: begin
              state_d = ON_PH;
            end
            PAUSE: begin
              pulse_d = '0;
              state_d = ON_PH;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end
    end

    always_comb begin
      out_d = (state_d == ON_PH) || (state_d == IDLE && mode_d == M_ON);
    end

    assign blink_o[g] = out_q;
  end

endmodule
